// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM access arbiter.
//   arb_state_t : burst-level FSM encoding (2 bits), exported on o_dbg_state.
//   owner_t     : which client currently owns (or last owned) the SDRAM port.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_DATA    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_READ  = 1'b0,
    OWN_WRITE = 1'b1
  } owner_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Grant decision for the SDRAM arbiter plus the write-starvation counter.
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   decide        arbiter is idle and may take a decision this cycle
//   wr_pend       registered writer request
//   rd_pend       registered reader request
//   rd_urgent     registered VGA low-water flag
//   last_owner    owner of the most recently completed burst
//   grant_wr      grant the writer this cycle (combinational)
//   grant_rd      grant the reader this cycle (combinational)
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int unsigned StarveLimit = 4
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   decide,
  input  logic   wr_pend,
  input  logic   rd_pend,
  input  logic   rd_urgent,
  input  owner_t last_owner,
  output logic   grant_wr,
  output logic   grant_rd
);

  localparam int unsigned StarveWidth = $clog2(StarveLimit + 1);

  logic [StarveWidth-1:0] starve_cnt_q;
  logic                   starved;

  assign starved = (starve_cnt_q >= StarveWidth'(StarveLimit));

  // First match wins: starved writer, urgent reader, round-robin, single requester.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (decide) begin
      if (wr_pend && starved) begin
        grant_wr = 1'b1;
      end else if (rd_pend && rd_urgent) begin
        grant_rd = 1'b1;
      end else if (wr_pend && rd_pend) begin
        if (last_owner == OWN_READ) grant_wr = 1'b1;
        else                        grant_rd = 1'b1;
      end else if (wr_pend) begin
        grant_wr = 1'b1;
      end else if (rd_pend) begin
        grant_rd = 1'b1;
      end
    end
  end

  // Counts read grants handed out while the writer waits; saturates at the limit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt_q <= '0;
    end else if (grant_wr) begin
      starve_cnt_q <= '0;
    end else if (grant_rd && wr_pend && !starved) begin
      starve_cnt_q <= starve_cnt_q + StarveWidth'(1);
    end
  end

endmodule

// File: rtl/sdram_access_arbiter.sv
// Shares the single SDRAM controller port between the frame writer and the
// VGA line-fetch reader, one whole burst at a time.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   i_wr_req/i_wr_addr       writer burst request (held until o_wr_grant) and start address
//   i_wr_data                writer current beat, forwarded on o_sdram_wdata
//   o_wr_grant, o_wr_valid   writer grant pulse, write beat consumed
//   i_rd_req/i_rd_addr       reader burst request (held until o_rd_grant) and start address
//   i_rd_urgent              VGA line FIFO below low-water mark
//   o_rd_grant               reader grant pulse
//   o_rd_valid/o_rd_data     read beat, one cycle after the controller strobe
//   o_cmd_valid/we/addr      burst command to the SDRAM controller
//   i_cmd_ready              controller accepts command
//   i_beat_wr, i_beat_rd     controller data-beat strobes; i_rd_beat_data read beat
//   o_busy                   burst in progress (state != IDLE)
//   o_err                    sticky stray-strobe flag
//   o_dbg_state              FSM state
// Handshake: the command transfers on the cycle o_cmd_valid && i_cmd_ready are
// both high; o_cmd_we/o_cmd_addr are stable from grant until that cycle.
// Beat strobes are single-cycle events with no back-pressure; a strobe only
// counts in DATA and for the owning direction, anything else raises o_err.
module sdram_access_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned BurstLengthSDRAM  = 8,
  parameter int unsigned PixelBitWidth     = 16,
  parameter int unsigned AddressWidthSDRAM = 24,
  parameter int unsigned StarveLimit       = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         i_wr_req,
  input  logic [AddressWidthSDRAM-1:0] i_wr_addr,
  input  logic [PixelBitWidth-1:0]     i_wr_data,
  output logic                         o_wr_grant,
  output logic                         o_wr_valid,
  input  logic                         i_rd_req,
  input  logic [AddressWidthSDRAM-1:0] i_rd_addr,
  input  logic                         i_rd_urgent,
  output logic                         o_rd_grant,
  output logic                         o_rd_valid,
  output logic [PixelBitWidth-1:0]     o_rd_data,
  output logic                         o_cmd_valid,
  output logic                         o_cmd_we,
  output logic [AddressWidthSDRAM-1:0] o_cmd_addr,
  input  logic                         i_cmd_ready,
  output logic [PixelBitWidth-1:0]     o_sdram_wdata,
  input  logic                         i_beat_wr,
  input  logic                         i_beat_rd,
  input  logic [PixelBitWidth-1:0]     i_rd_beat_data,
  output logic                         o_busy,
  output logic                         o_err,
  output arb_state_t                   o_dbg_state
);

  localparam int unsigned BeatWidth = $clog2(BurstLengthSDRAM) + 1;

  arb_state_t                   state_q, state_d;
  owner_t                       owner_q, last_owner_q;
  logic [BeatWidth-1:0]         beat_cnt_q;
  logic                         wr_req_q, rd_req_q, rd_urgent_q;
  logic                         wr_grant_q, rd_grant_q;
  logic                         cmd_we_q;
  logic [AddressWidthSDRAM-1:0] cmd_addr_q;
  logic                         rd_valid_q;
  logic [PixelBitWidth-1:0]     rd_data_q;
  logic                         err_q;

  logic grant_wr, grant_rd;
  logic in_idle, in_issue, in_data, in_release;
  logic wr_hit, rd_hit, beat_hit, stray;
  logic last_beat;

  sdram_arb_pick #(
    .StarveLimit (StarveLimit)
  ) u_pick (
    .CLK        (CLK),
    .RST        (RST),
    .decide     (in_idle),
    .wr_pend    (wr_req_q),
    .rd_pend    (rd_req_q),
    .rd_urgent  (rd_urgent_q),
    .last_owner (last_owner_q),
    .grant_wr   (grant_wr),
    .grant_rd   (grant_rd)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (grant_wr || grant_rd) state_d = ST_ISSUE;
      ST_ISSUE:   if (i_cmd_ready)          state_d = ST_DATA;
      ST_DATA:    if (beat_hit && last_beat) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / strobe decode. A strobe in the ISSUE cycle that carries
  // i_cmd_ready is outside DATA and therefore not counted.
  always_comb begin
    in_idle    = (state_q == ST_IDLE);
    in_issue   = (state_q == ST_ISSUE);
    in_data    = (state_q == ST_DATA);
    in_release = (state_q == ST_RELEASE);
    wr_hit     = in_data && (owner_q == OWN_WRITE) && i_beat_wr;
    rd_hit     = in_data && (owner_q == OWN_READ)  && i_beat_rd;
    beat_hit   = wr_hit || rd_hit;
    stray      = (i_beat_wr && !wr_hit) || (i_beat_rd && !rd_hit);
    last_beat  = (beat_cnt_q == BeatWidth'(BurstLengthSDRAM - 1));
  end

  // Datapath: request sampling, grant pulses, command latch, beat counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_urgent_q  <= 1'b0;
      wr_grant_q   <= 1'b0;
      rd_grant_q   <= 1'b0;
      owner_q      <= OWN_READ;
      last_owner_q <= OWN_READ;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      beat_cnt_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      wr_req_q    <= i_wr_req;
      rd_req_q    <= i_rd_req;
      rd_urgent_q <= i_rd_urgent;
      wr_grant_q  <= grant_wr;
      rd_grant_q  <= grant_rd;
      // Command fields are captured at the decision so a requester may drop
      // or change its lines once it sees the grant.
      if (grant_wr || grant_rd) begin
        owner_q    <= grant_wr ? OWN_WRITE : OWN_READ;
        cmd_we_q   <= grant_wr;
        cmd_addr_q <= grant_wr ? i_wr_addr : i_rd_addr;
      end
      if (beat_hit)        beat_cnt_q <= beat_cnt_q + BeatWidth'(1);
      else if (in_release) beat_cnt_q <= '0;
      if (in_release) last_owner_q <= owner_q;
      rd_valid_q <= rd_hit;
      if (rd_hit) rd_data_q <= i_rd_beat_data;
      if (stray) err_q <= 1'b1;
    end
  end

  assign o_wr_grant    = wr_grant_q;
  assign o_rd_grant    = rd_grant_q;
  assign o_wr_valid    = wr_hit;
  assign o_rd_valid    = rd_valid_q;
  assign o_rd_data     = rd_data_q;
  assign o_cmd_valid   = in_issue;
  assign o_cmd_we      = cmd_we_q;
  assign o_cmd_addr    = cmd_addr_q;
  assign o_sdram_wdata = i_wr_data;
  assign o_busy        = !in_idle;
  assign o_err         = err_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_sdram_access_arbiter.sv
module tb_sdram_access_arbiter;
  import sdram_arb_pkg::*;

  localparam int BL  = 8;
  localparam int PW  = 16;
  localparam int AW  = 24;
  localparam int SL  = 4;
  localparam int TMO = 1000;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic          i_wr_req, i_rd_req, i_rd_urgent;
  logic [AW-1:0] i_wr_addr, i_rd_addr;
  logic [PW-1:0] i_wr_data;
  logic          o_wr_grant, o_wr_valid, o_rd_grant, o_rd_valid;
  logic [PW-1:0] o_rd_data, o_sdram_wdata;
  logic          o_cmd_valid, o_cmd_we, o_busy, o_err;
  logic [AW-1:0] o_cmd_addr;
  arb_state_t    o_dbg_state;
  logic          i_cmd_ready, i_beat_wr, i_beat_rd;
  logic [PW-1:0] i_rd_beat_data;

  // Controller-side inputs come from the automatic controller model or from
  // directed code in the main block, selected by ctrl_en.
  logic          ctrl_en = 1'b0;
  logic          c_ready = 1'b0, c_beat_wr = 1'b0, c_beat_rd = 1'b0;
  logic [PW-1:0] c_rdata = '0;
  logic          m_ready = 1'b0, m_beat_wr = 1'b0, m_beat_rd = 1'b0;
  logic [PW-1:0] m_rdata = '0;
  assign i_cmd_ready    = ctrl_en ? c_ready   : m_ready;
  assign i_beat_wr      = ctrl_en ? c_beat_wr : m_beat_wr;
  assign i_beat_rd      = ctrl_en ? c_beat_rd : m_beat_rd;
  assign i_rd_beat_data = ctrl_en ? c_rdata   : m_rdata;

  sdram_access_arbiter dut (
    .CLK            (CLK),
    .RST            (RST),
    .i_wr_req       (i_wr_req),
    .i_wr_addr      (i_wr_addr),
    .i_wr_data      (i_wr_data),
    .o_wr_grant     (o_wr_grant),
    .o_wr_valid     (o_wr_valid),
    .i_rd_req       (i_rd_req),
    .i_rd_addr      (i_rd_addr),
    .i_rd_urgent    (i_rd_urgent),
    .o_rd_grant     (o_rd_grant),
    .o_rd_valid     (o_rd_valid),
    .o_rd_data      (o_rd_data),
    .o_cmd_valid    (o_cmd_valid),
    .o_cmd_we       (o_cmd_we),
    .o_cmd_addr     (o_cmd_addr),
    .i_cmd_ready    (i_cmd_ready),
    .o_sdram_wdata  (o_sdram_wdata),
    .i_beat_wr      (i_beat_wr),
    .i_beat_rd      (i_beat_rd),
    .i_rd_beat_data (i_rd_beat_data),
    .o_busy         (o_busy),
    .o_err          (o_err),
    .o_dbg_state    (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic          exp_own_q[$];   // 1 = write grant, 0 = read grant
  logic [AW:0]   exp_cmd_q[$];   // {we, addr}
  logic [PW-1:0] exp_wr_q[$];
  logic [PW-1:0] exp_rd_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Reference model state: burst-level arbitration rules.
  int      m_starve = 0;
  logic    m_last   = 1'b0;   // 1 = last burst was a write
  logic [AW-1:0] wr_addr_a [8];
  logic [AW-1:0] rd_addr_a [8];
  logic [PW-1:0] wr_data_a [8][BL];

  // Computes the grant order for a scenario where each client keeps its
  // request asserted until its final burst is granted.
  task automatic model_scenario(input int nw, input int nr, input logic urg);
    int  w = 0;
    int  r = 0;
    bit  wp, rp, take_w;
    while (w < nw || r < nr) begin
      wp = (w < nw);
      rp = (r < nr);
      if (wp && m_starve >= SL)  take_w = 1'b1;
      else if (rp && urg)        take_w = 1'b0;
      else if (wp && rp)         take_w = !m_last;
      else                       take_w = wp;
      if (take_w) begin
        exp_own_q.push_back(1'b1);
        exp_cmd_q.push_back({1'b1, wr_addr_a[w]});
        for (int b = 0; b < BL; b++) exp_wr_q.push_back(wr_data_a[w][b]);
        m_starve = 0;
        m_last   = 1'b1;
        w++;
      end else begin
        exp_own_q.push_back(1'b0);
        exp_cmd_q.push_back({1'b0, rd_addr_a[r]});
        if (wp && m_starve < SL) m_starve++;
        m_last = 1'b0;
        r++;
      end
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents an event.
  logic          mon_own;
  logic [AW:0]   mon_cmd;
  logic [PW-1:0] mon_dat;
  always @(negedge CLK) begin
    if (!RST) begin
      if (o_wr_grant && o_rd_grant) flag_fail("grant_excl", "both grants high");
      if (o_wr_grant || o_rd_grant) begin
        if (exp_own_q.size() == 0) flag_fail("grant_owner", "unexpected grant");
        else begin
          mon_own = exp_own_q.pop_front();
          check("grant_owner", {63'd0, o_wr_grant}, {63'd0, mon_own});
        end
      end
      if (o_cmd_valid && i_cmd_ready) begin
        if (exp_cmd_q.size() == 0) flag_fail("cmd", "unexpected command handshake");
        else begin
          mon_cmd = exp_cmd_q.pop_front();
          check("cmd", {39'd0, o_cmd_we, o_cmd_addr}, {39'd0, mon_cmd});
        end
      end
      if (o_wr_valid) begin
        if (exp_wr_q.size() == 0) flag_fail("wr_beat", "unexpected o_wr_valid");
        else begin
          mon_dat = exp_wr_q.pop_front();
          check("wr_beat", {48'd0, o_sdram_wdata}, {48'd0, mon_dat});
        end
      end
      if (o_rd_valid) begin
        if (exp_rd_q.size() == 0) flag_fail("rd_beat", "unexpected o_rd_valid");
        else begin
          mon_dat = exp_rd_q.pop_front();
          check("rd_beat", {48'd0, o_rd_data}, {48'd0, mon_dat});
        end
      end
    end
  end

  // ---------------- SDRAM controller model ----------------
  initial begin : sdram_ctrl
    int            d, g;
    logic          we;
    logic [PW-1:0] rdat;
    forever begin
      @(posedge CLK); #1;
      if (ctrl_en && o_cmd_valid) begin
        we = o_cmd_we;
        d  = $urandom_range(0, 3);
        repeat (d) begin @(posedge CLK); #1; end
        c_ready = 1'b1;
        @(posedge CLK); #1;
        c_ready = 1'b0;
        for (int b = 0; b < BL; b++) begin
          g = $urandom_range(0, 2);
          repeat (g) begin @(posedge CLK); #1; end
          if (we) c_beat_wr = 1'b1;
          else begin
            rdat      = PW'($urandom);
            c_rdata   = rdat;
            c_beat_rd = 1'b1;
            exp_rd_q.push_back(rdat);
          end
          @(posedge CLK); #1;
          c_beat_wr = 1'b0;
          c_beat_rd = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_writer(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      i_wr_addr = wr_addr_a[k];
      i_wr_data = wr_data_a[k][0];
      i_wr_req  = 1'b1;
      t = 0;
      do begin @(negedge CLK); t++; end while (!o_wr_grant && t < TMO);
      if (!o_wr_grant) begin
        flag_fail("wr_grant_wait", "timeout");
        i_wr_req = 1'b0;
        return;
      end
      if (k == n - 1) begin
        @(posedge CLK); #1;
        i_wr_req = 1'b0;
      end
      for (int b = 0; b < BL; b++) begin
        t = 0;
        do begin @(negedge CLK); t++; end while (!o_wr_valid && t < TMO);
        if (!o_wr_valid) begin
          flag_fail("wr_valid_wait", "timeout");
          return;
        end
        @(posedge CLK); #1;
        if (b < BL - 1) i_wr_data = wr_data_a[k][b+1];
      end
    end
  endtask

  task automatic run_reader(input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      i_rd_addr = rd_addr_a[k];
      i_rd_req  = 1'b1;
      t = 0;
      do begin @(negedge CLK); t++; end while (!o_rd_grant && t < TMO);
      if (!o_rd_grant) begin
        flag_fail("rd_grant_wait", "timeout");
        i_rd_req = 1'b0;
        return;
      end
      @(posedge CLK); #1;
      if (k == n - 1) i_rd_req = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((o_busy || exp_own_q.size() != 0 || exp_cmd_q.size() != 0 ||
            exp_wr_q.size() != 0 || exp_rd_q.size() != 0) && t < TMO) begin
      @(negedge CLK);
      t++;
    end
    check({name, "_idle"}, {63'd0, o_busy}, 64'd0);
    check({name, "_queues"}, 64'(exp_own_q.size() + exp_cmd_q.size() +
                                 exp_wr_q.size() + exp_rd_q.size()), 64'd0);
    check({name, "_err"}, {63'd0, o_err}, 64'd0);
    exp_own_q.delete(); exp_cmd_q.delete(); exp_wr_q.delete(); exp_rd_q.delete();
    @(posedge CLK); #1;
  endtask

  task automatic run_scenario(input string name, input int nw, input int nr, input logic urg);
    for (int k = 0; k < 8; k++) begin
      wr_addr_a[k] = AW'($urandom);
      rd_addr_a[k] = AW'($urandom);
      for (int b = 0; b < BL; b++) wr_data_a[k][b] = PW'($urandom);
    end
    model_scenario(nw, nr, urg);
    i_rd_urgent = urg;
    fork
      run_writer(nw);
      run_reader(nr);
    join
    wait_drain(name);
    i_rd_urgent = 1'b0;
  endtask

  task automatic drive_rd_beats(input int n, input int n_push);
    logic [PW-1:0] d;
    for (int b = 0; b < n; b++) begin
      d         = PW'($urandom);
      m_rdata   = d;
      m_beat_rd = 1'b1;
      if (b < n_push) exp_rd_q.push_back(d);
      @(posedge CLK); #1;
      m_beat_rd = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_outs"},
          {22'd0, o_wr_grant, o_wr_valid, o_rd_grant, o_rd_valid, o_rd_data,
           o_cmd_valid, o_cmd_we, o_cmd_addr, o_busy, o_err}, 64'd0);
    check({name, "_state"}, {62'd0, o_dbg_state}, {62'd0, ST_IDLE});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [AW-1:0] a;
  int            t;
  initial begin
    RST = 1'b1;
    i_wr_req = 1'b0; i_rd_req = 1'b0; i_rd_urgent = 1'b0;
    i_wr_addr = '0; i_rd_addr = '0; i_wr_data = '0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    ctrl_en = 1'b1;

    // Both requesting together after reset: write first, then alternate.
    run_scenario("rr_both", 2, 2, 1'b0);
    // Single writer burst.
    run_scenario("write_only", 1, 0, 1'b0);
    // Urgent reader starving the writer: four reads, then the write.
    run_scenario("urgent", 2, 6, 1'b1);
    check("starve_after_urgent", 64'(dut.u_pick.starve_cnt_q), 64'(m_starve));

    for (int s = 0; s < 6; s++) begin
      run_scenario("random", $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 2) == 0));
    end

    // Command stalled: held stable, nothing counted while waiting.
    ctrl_en = 1'b0;
    a = AW'($urandom);
    i_rd_addr = a;
    i_rd_req  = 1'b1;
    exp_own_q.push_back(1'b0);
    exp_cmd_q.push_back({1'b0, a});
    m_last = 1'b0;
    t = 0;
    do begin @(negedge CLK); t++; end while (!o_rd_grant && t < TMO);
    if (!o_rd_grant) flag_fail("stall_grant", "timeout");
    @(posedge CLK); #1;
    i_rd_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("stall_cmd", {38'd0, o_cmd_valid, o_cmd_we, o_cmd_addr}, {38'd0, 1'b1, 1'b0, a});
      check("stall_state", {62'd0, o_dbg_state}, {62'd0, ST_ISSUE});
    end
    @(posedge CLK); #1;
    m_ready = 1'b1;
    @(posedge CLK); #1;
    m_ready = 1'b0;
    drive_rd_beats(BL, BL);
    wait_drain("stall");

    // Reset in the middle of a read burst.
    a = AW'($urandom);
    i_rd_addr = a;
    i_rd_req  = 1'b1;
    exp_own_q.push_back(1'b0);
    exp_cmd_q.push_back({1'b0, a});
    t = 0;
    do begin @(negedge CLK); t++; end while (!o_rd_grant && t < TMO);
    if (!o_rd_grant) flag_fail("rst_grant", "timeout");
    @(posedge CLK); #1;
    i_rd_req = 1'b0;
    m_ready  = 1'b1;
    @(posedge CLK); #1;
    m_ready  = 1'b0;
    drive_rd_beats(2, 1);
    m_rdata   = PW'($urandom);
    m_beat_rd = 1'b1;
    #2 RST = 1'b1;
    #1;
    check_outputs_zero("rst_mid");
    m_beat_rd = 1'b0;
    m_starve  = 0;
    m_last    = 1'b0;
    exp_own_q.delete(); exp_cmd_q.delete(); exp_wr_q.delete(); exp_rd_q.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    check_outputs_zero("after_rst");
    ctrl_en = 1'b1;
    run_scenario("post_rst", 1, 1, 1'b0);

    // Stray strobes while idle: ignored, sticky error.
    ctrl_en = 1'b0;
    check("err_before", {63'd0, o_err}, 64'd0);
    m_rdata   = PW'($urandom);
    m_beat_rd = 1'b1;
    @(posedge CLK); #1;
    m_beat_rd = 1'b0;
    m_beat_wr = 1'b1;
    @(negedge CLK);
    check("stray_wr_valid", {63'd0, o_wr_valid}, 64'd0);
    @(posedge CLK); #1;
    m_beat_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("stray_err", {63'd0, o_err}, 64'd1);
      check("stray_rd_valid", {63'd0, o_rd_valid}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
